cursor_overlay_renderer: RTL and testbench
==========================================

Name: cursor_overlay_renderer

Overview:
- Display-side consumer of the push-button adapter's cursor index and active-period selection on the 480x272 TFT43 panel.
- Sits in the pixel path between the waveform/background pixel source and the LCD driver.
- Overlays an 11-item menu column:
  - a blinking border on the cursor item;
  - a solid fill on the item matching the active SIN-period count.
- Menu state is sampled once per frame, so no tearing occurs.

Parameters:
- NUM_ITEMS, 11, menu items 0..10 (cursor index range).
- ITEM_X0, 400, left pixel column of the menu column; the column spans ITEM_X0..479.
- ITEM_H, 24, item height in rows; item i covers rows i*ITEM_H .. i*ITEM_H+ITEM_H-1.
- BORDER_W, 2, cursor border thickness in pixels.
- BLINK_FRAMES, 30, frames per blink half-period.
- CURSOR_COLOR, 16'hF800, RGB565 border colour.
- ACTIVE_COLOR, 16'h07E0, RGB565 fill colour for the active period item.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  overlay enable.
- iCursor_Index  in  4  cursor index from the button adapter.
- iActive_Periods_Num  in  3  0..4 = Period1..Period5.
- iFrame_Start  in  1  one-cycle pulse, first pixel of a frame.
- iPixel_Valid  in  1  qualifies iPixel_X, iPixel_Y and iBg_Color.
- iPixel_X  in  10  column, 0..479.
- iPixel_Y  in  9  row, 0..271.
- iBg_Color  in  16  underlying RGB565 pixel.
- oPixel_Valid  out  1  iPixel_Valid delayed by 2 cycles.
- oPixel_Color  out  16  composited RGB565 pixel.
- oBlink_Phase  out  1  current blink phase (1 = border visible); provided for debug.

Behaviour:
- Reset values:
  - oPixel_Valid=0, oPixel_Color=0, oBlink_Phase=1.
  - Shadow cursor=0, shadow periods=0.
  - Blink counter=0, both pipeline stages cleared.
- Latency: fixed 2 cycles, valid or not. Not back-pressured; one pixel per cycle accepted.
- Shadow registers:
  - iCursor_Index and iActive_Periods_Num are captured only on cycles with iFrame_Start=1.
  - Stage 1 in the iFrame_Start cycle uses the incoming values (bypass), so pixel (0,0) is already coherent.
- Stage 1 computes, from X, Y and the effective shadow values:
  - hit: X>=ITEM_X0 and Y<NUM_ITEMS*ITEM_H;
  - item row index r;
  - border flag: pixel within BORDER_W of any box edge of item r.
  - r may be derived with a comparator chain; no generic divider.
- Stage 2 colour select, highest priority first:
  1. hit && r==cursor && border && blink_phase -> CURSOR_COLOR;
  2. hit && r==periods && periods<=4 -> ACTIVE_COLOR;
  3. otherwise -> iBg_Color delayed by 2 cycles.
- Out-of-range values:
  - Shadow cursor >10 gives no border.
  - Shadow periods >4 gives no fill.
  - Pixels with X>479 or Y>=264 pass through.
- Blink timer:
  - Counter increments on iFrame_Start while en=1.
  - At BLINK_FRAMES-1 the counter wraps to 0 and oBlink_Phase toggles.
  - When a captured cursor differs from the previous shadow cursor: counter←0 and phase←1, so the border is immediately visible after a move.
- en=0:
  - Output = iBg_Color (2-cycle latency kept).
  - Blink counter←0, phase←1, shadows←0.
  - Pipeline valid still propagates.
- Reset mid-frame: all stages clear asynchronously; output resumes with the next iPixel_Valid. Shadows stay 0 until the next iFrame_Start.

Decomposition:
- Shared package:
  - LCD geometry (480, 272);
  - RGB565 colour constants;
  - ZCURSOR_INDEX_PERIOD1..PERIOD5 (=0..4);
  - MAX_CURSOR_INDEX=10;
  - menu layout constants.
- One sub-module, cursor_blink_timer:
  - inputs: frame pulse, en, cursor-changed pulse;
  - output: phase.

Test Plan:
- Reset, en=1, frame with cursor=3, periods=1 -> pixel (400,72) is F800; (410,34) is 07E0; (100,100) bg is passed through after exactly 2 cycles.
- Change iCursor_Index 3→4 mid-frame -> rows 72..95 keep the border until the next iFrame_Start; next frame shows the border at rows 96..119 with oBlink_Phase=1.
- Hold cursor constant for 60 frames -> oBlink_Phase toggles after frames 30 and 60; border pixel alternates F800 / bg.
- cursor=12 or periods=6 -> no F800 or 07E0 anywhere; all pixels equal bg.
- cursor==periods==2 -> border pixels (400,48) F800, interior (420,60) 07E0.
- en deasserted mid-frame, plus async rst_n pulse -> output equals bg delayed 2 cycles, oPixel_Valid=0 during reset, phase=1 afterwards.

Source files
------------

// File: rtl/cursor_overlay_renderer_pkg.sv
// Shared constants and types for the TFT43 menu cursor overlay.
// Panel geometry, RGB565 colours, menu layout and period cursor indices.
package cursor_overlay_renderer_pkg;

  localparam int unsigned LCD_W     = 480;
  localparam int unsigned LCD_H     = 272;
  localparam int unsigned X_W       = 10;
  localparam int unsigned Y_W       = 9;
  localparam int unsigned COLOR_W   = 16;
  localparam int unsigned CURSOR_W  = 4;
  localparam int unsigned PERIODS_W = 3;
  localparam int unsigned ROW_W     = 4;

  localparam logic [COLOR_W-1:0] COLOR_BLACK  = 16'h0000;
  localparam logic [COLOR_W-1:0] CURSOR_COLOR = 16'hF800;
  localparam logic [COLOR_W-1:0] ACTIVE_COLOR = 16'h07E0;

  localparam int unsigned ZCURSOR_INDEX_PERIOD1 = 0;
  localparam int unsigned ZCURSOR_INDEX_PERIOD2 = 1;
  localparam int unsigned ZCURSOR_INDEX_PERIOD3 = 2;
  localparam int unsigned ZCURSOR_INDEX_PERIOD4 = 3;
  localparam int unsigned ZCURSOR_INDEX_PERIOD5 = 4;
  localparam int unsigned MAX_CURSOR_INDEX      = 10;

  localparam int unsigned NUM_ITEMS    = 11;
  localparam int unsigned ITEM_X0      = 400;
  localparam int unsigned ITEM_H       = 24;
  localparam int unsigned BORDER_W     = 2;
  localparam int unsigned BLINK_FRAMES = 30;
  localparam int unsigned MENU_H       = NUM_ITEMS * ITEM_H;

  // Stage-1 result carried to the colour select stage.
  typedef struct packed {
    logic               valid;
    logic               cursor_hit;
    logic               active_hit;
    logic [COLOR_W-1:0] bg;
  } stage1_t;

endpackage

// File: rtl/cursor_blink_timer.sv
// Frame-counted blink phase for the cursor border.
// Restarts in the visible phase on a cursor move or while disabled.
module cursor_blink_timer
  import cursor_overlay_renderer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic frame_start,
  input  logic cursor_changed,
  output logic phase
);

  localparam int unsigned CNT_W = $clog2(BLINK_FRAMES);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (!en || cursor_changed) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (frame_start) begin
      if (cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cursor_overlay_renderer.sv
// Two-stage pixel pipeline overlaying the menu cursor border and active-period fill.
// Menu state is shadowed per frame; the frame-start pixel bypasses to the live inputs.
module cursor_overlay_renderer
  import cursor_overlay_renderer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [CURSOR_W-1:0]  iCursor_Index,
  input  logic [PERIODS_W-1:0] iActive_Periods_Num,
  input  logic                 iFrame_Start,
  input  logic                 iPixel_Valid,
  input  logic [X_W-1:0]       iPixel_X,
  input  logic [Y_W-1:0]       iPixel_Y,
  input  logic [COLOR_W-1:0]   iBg_Color,
  output logic                 oPixel_Valid,
  output logic [COLOR_W-1:0]   oPixel_Color,
  output logic                 oBlink_Phase
);

  logic [CURSOR_W-1:0]  shadow_cursor;
  logic [PERIODS_W-1:0] shadow_periods;
  logic [CURSOR_W-1:0]  eff_cursor;
  logic [PERIODS_W-1:0] eff_periods;
  logic                 cursor_changed;
  logic [ROW_W-1:0]     row;
  logic [Y_W-1:0]       row_base;
  logic [Y_W-1:0]       y_off;
  logic                 hit;
  logic                 border;
  logic                 blink_phase;
  stage1_t              s1_d;
  stage1_t              s1_q;

  // Frame-coherent menu state, cleared while the overlay is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_cursor  <= '0;
      shadow_periods <= '0;
    end else if (!en) begin
      shadow_cursor  <= '0;
      shadow_periods <= '0;
    end else if (iFrame_Start) begin
      shadow_cursor  <= iCursor_Index;
      shadow_periods <= iActive_Periods_Num;
    end
  end

  always_comb begin
    eff_cursor     = iFrame_Start ? iCursor_Index : shadow_cursor;
    eff_periods    = iFrame_Start ? iActive_Periods_Num : shadow_periods;
    cursor_changed = en && iFrame_Start && (iCursor_Index != shadow_cursor);
  end

  // Item row via a comparator chain against the item top edges.
  always_comb begin
    row      = '0;
    row_base = '0;
    for (int unsigned i = 1; i < NUM_ITEMS; i++) begin
      if (iPixel_Y >= Y_W'(i * ITEM_H)) begin
        row      = ROW_W'(i);
        row_base = Y_W'(i * ITEM_H);
      end
    end
  end

  always_comb begin
    y_off  = iPixel_Y - row_base;
    hit    = (iPixel_X >= X_W'(ITEM_X0)) && (iPixel_X < X_W'(LCD_W)) &&
             (iPixel_Y < Y_W'(MENU_H));
    border = (iPixel_X < X_W'(ITEM_X0 + BORDER_W)) ||
             (iPixel_X >= X_W'(LCD_W - BORDER_W)) ||
             (y_off < Y_W'(BORDER_W)) ||
             (y_off >= Y_W'(ITEM_H - BORDER_W));

    s1_d            = '0;
    s1_d.valid      = iPixel_Valid;
    s1_d.bg         = iBg_Color;
    s1_d.cursor_hit = en && hit && border && (row == ROW_W'(eff_cursor)) &&
                      (eff_cursor <= CURSOR_W'(MAX_CURSOR_INDEX));
    s1_d.active_hit = en && hit && (row == ROW_W'(eff_periods)) &&
                      (eff_periods <= PERIODS_W'(ZCURSOR_INDEX_PERIOD5));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  // Stage 2: border beats fill beats background.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oPixel_Valid <= 1'b0;
      oPixel_Color <= COLOR_BLACK;
    end else begin
      oPixel_Valid <= s1_q.valid;
      if (s1_q.cursor_hit && blink_phase) begin
        oPixel_Color <= CURSOR_COLOR;
      end else if (s1_q.active_hit) begin
        oPixel_Color <= ACTIVE_COLOR;
      end else begin
        oPixel_Color <= s1_q.bg;
      end
    end
  end

  cursor_blink_timer u_blink (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .frame_start    (iFrame_Start),
    .cursor_changed (cursor_changed),
    .phase          (blink_phase)
  );

  assign oBlink_Phase = blink_phase;

endmodule

// File: tb/tb_cursor_overlay_renderer.sv
// Directed bench for cursor_overlay_renderer: a reference model queues expected pixels,
// and every output pixel is popped and checked for colour and 2-cycle latency.
module tb_cursor_overlay_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  iCursor_Index;
  logic [2:0]  iActive_Periods_Num;
  logic        iFrame_Start;
  logic        iPixel_Valid;
  logic [9:0]  iPixel_X;
  logic [8:0]  iPixel_Y;
  logic [15:0] iBg_Color;
  logic        oPixel_Valid;
  logic [15:0] oPixel_Color;
  logic        oBlink_Phase;

  cursor_overlay_renderer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .en                  (en),
    .iCursor_Index       (iCursor_Index),
    .iActive_Periods_Num (iActive_Periods_Num),
    .iFrame_Start        (iFrame_Start),
    .iPixel_Valid        (iPixel_Valid),
    .iPixel_X            (iPixel_X),
    .iPixel_Y            (iPixel_Y),
    .iBg_Color           (iBg_Color),
    .oPixel_Valid        (oPixel_Valid),
    .oPixel_Color        (oPixel_Color),
    .oBlink_Phase        (oBlink_Phase)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] color;
    int          x;
    int          y;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Bench-side stimulus state and reference model state.
  logic       en_in  = 1'b1;
  logic [3:0] cur_in = 4'd0;
  logic [2:0] per_in = 3'd0;
  int         m_cur  = 0;
  int         m_per  = 0;
  int         m_cnt  = 0;
  logic       m_ph   = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] model(input int x, input int y, input logic [15:0] bg);
    int r;
    int yo;
    logic brd;
    if (!en_in) return bg;
    if (x >= 400 && x < 480 && y < 264) begin
      r   = y / 24;
      yo  = y % 24;
      brd = (x < 402) || (x > 477) || (yo < 2) || (yo > 21);
      if (r == m_cur && m_cur <= 10 && brd && m_ph) return 16'hF800;
      if (r == m_per && m_per <= 4) return 16'h07E0;
    end
    return bg;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_ph  = 1'b1;
    m_cur = 0;
    m_per = 0;
  endtask

  task automatic monitor();
    exp_t e;
    if (oPixel_Valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 32'(oPixel_Valid), 32'd0);
      end else begin
        e = q.pop_front();
        check($sformatf("latency(%0d,%0d)", e.x, e.y), 32'(cyc), 32'(e.cyc + 2));
        check($sformatf("color(%0d,%0d)", e.x, e.y), 32'(oPixel_Color), 32'(e.color));
      end
    end else if (q.size() > 0 && cyc >= q[0].cyc + 2) begin
      e = q.pop_front();
      check($sformatf("missing_valid(%0d,%0d)", e.x, e.y), 32'(oPixel_Valid), 32'd1);
    end
  endtask

  // One pixel clock: drive after the edge, update the model, sample at the falling edge.
  task automatic cycle(input bit v, input int x, input int y, input bit fs);
    logic [15:0] bg;
    @(posedge clk);
    #1;
    bg                  = 16'($urandom);
    en                  = en_in;
    iCursor_Index       = cur_in;
    iActive_Periods_Num = per_in;
    iFrame_Start        = fs;
    iPixel_Valid        = v;
    iPixel_X            = 10'(x);
    iPixel_Y            = 9'(y);
    iBg_Color           = bg;
    if (!en_in) model_reset();
    if (fs && en_in) begin
      if (int'(cur_in) != m_cur) begin
        m_cnt = 0;
        m_ph  = 1'b1;
      end else if (m_cnt == 29) begin
        m_cnt = 0;
        m_ph  = ~m_ph;
      end else begin
        m_cnt++;
      end
      m_cur = int'(cur_in);
      m_per = int'(per_in);
    end
    if (v && rst_n) q.push_back('{cyc, model(x, y, bg), x, y});
    @(negedge clk);
    monitor();
  endtask

  task automatic frame(input int c, input int p);
    cur_in = 4'(c);
    per_in = 3'(p);
    cycle(1'b1, 0, 0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int xs[8];
    int ys[10];
    rst_n = 1'b0;
    en = 1'b1; iCursor_Index = '0; iActive_Periods_Num = '0; iFrame_Start = 1'b0;
    iPixel_Valid = 1'b0; iPixel_X = '0; iPixel_Y = '0; iBg_Color = '0;
    xs = '{398, 399, 400, 401, 440, 478, 479, 480};
    ys = '{0, 1, 23, 24, 47, 48, 60, 263, 264, 271};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(oPixel_Valid), 32'd0);
    check("rst_color", 32'(oPixel_Color), 32'd0);
    check("rst_phase", 32'(oBlink_Phase), 32'd1);
    #2 rst_n = 1'b1;

    // Cursor 3, periods 1
    frame(3, 1);
    cycle(1'b1, 400, 72, 1'b0);
    cycle(1'b1, 410, 34, 1'b0);
    cycle(1'b1, 100, 100, 1'b0);
    cycle(1'b1, 479, 95, 1'b0);
    cycle(1'b1, 420, 80, 1'b0);
    check("phase_after_move", 32'(oBlink_Phase), 32'd1);

    // Mid-frame cursor change waits for the next frame
    cur_in = 4'd4;
    cycle(1'b1, 400, 72, 1'b0);
    cycle(1'b1, 400, 96, 1'b0);
    frame(4, 1);
    cycle(1'b1, 400, 96, 1'b0);
    cycle(1'b1, 450, 119, 1'b0);
    cycle(1'b1, 400, 72, 1'b0);
    check("phase_new_cursor", 32'(oBlink_Phase), 32'd1);

    // Held cursor: blink toggles every 30 frames
    for (int i = 1; i <= 60; i++) begin
      frame(4, 1);
      cycle(1'b1, 400, 96, 1'b0);
      check($sformatf("phase_frame%0d", i), 32'(oBlink_Phase), 32'(m_ph));
      if (i == 30) check("phase_after30", 32'(oBlink_Phase), 32'd0);
      if (i == 60) check("phase_after60", 32'(oBlink_Phase), 32'd1);
    end

    // Out-of-range cursor and periods: everything is background
    frame(12, 6);
    foreach (xs[i]) foreach (ys[j]) cycle(1'b1, xs[i], ys[j], 1'b0);

    // Cursor and periods on the same item
    frame(2, 2);
    cycle(1'b1, 400, 48, 1'b0);
    cycle(1'b1, 420, 60, 1'b0);
    cycle(1'b1, 479, 71, 1'b0);
    cycle(1'b1, 440, 70, 1'b0);

    // Disable mid-frame: background only, valid still flows
    en_in = 1'b0;
    cycle(1'b1, 400, 48, 1'b0);
    cycle(1'b1, 420, 60, 1'b0);
    cycle(1'b1, 100, 100, 1'b0);
    check("phase_disabled", 32'(oBlink_Phase), 32'd1);

    // Async reset with pixels in flight
    cycle(1'b1, 401, 49, 1'b0);
    cycle(1'b1, 402, 50, 1'b0);
    cycle(1'b1, 403, 51, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(oPixel_Valid), 32'd0);
    check("async_rst_color", 32'(oPixel_Color), 32'd0);
    q.delete();
    model_reset();
    idle(3);
    check("rst_hold_valid", 32'(oPixel_Valid), 32'd0);
    #2 rst_n = 1'b1;

    // After reset: shadows are 0 until the next frame start
    en_in = 1'b1;
    cycle(1'b1, 400, 0, 1'b0);
    cycle(1'b1, 420, 10, 1'b0);
    cycle(1'b1, 200, 10, 1'b0);
    check("phase_post_reset", 32'(oBlink_Phase), 32'd1);
    frame(5, 0);
    cycle(1'b1, 478, 120, 1'b0);
    cycle(1'b1, 430, 5, 1'b0);
    cycle(1'b1, 400, 0, 1'b0);

    idle(4);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
